// File: rtl/top_v1_pkg.sv
// Shared sizing and slice-index helpers for the 2x2-output tiled 3x3 convolution.
// Every helper takes the module parameters as arguments, so one package serves any instance.
package top_v1_pkg;

  localparam int SUPPORTED_K = 3;

  function automatic int out_tile(input int t, input int k);
    return t - k + 1;
  endfunction

  function automatic int out_width(input int kw, input int dw);
    return kw + dw + 13;
  endfunction

  function automatic int tiles_per_dim(input int w, input int k, input int m);
    return (w - k + 1) / m;
  endfunction

  function automatic int kernel_idx(input int ch, input int kr, input int kc,
                                    input int k, input int kw);
    return ((ch * k + kr) * k + kc) * kw;
  endfunction

  function automatic int out_idx(input int r, input int c, input int m, input int ow);
    return (r * m + c) * ow;
  endfunction

  // Layout of the flattened T x T x C tile: channel-major, then row, then column.
  function automatic int tile_idx(input int ch, input int r, input int c,
                                  input int t, input int dw);
    return ((ch * t + r) * t + c) * dw;
  endfunction

  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_conv_2x2.sv
// Direct-form 3x3 convolution of one 4x4xC tile into a 2x2 block of outputs.
// Each output is summed over channels, with unsigned pixels and signed coefficients.
module tile_conv_2x2
  import top_v1_pkg::*;
#(
  parameter int K  = 3,
  parameter int T  = 4,
  parameter int DW = 8,
  parameter int KW = 8,
  parameter int C  = 3,
  parameter int M  = 2,
  parameter int OW = 29
) (
  input  logic [T*T*DW*C-1:0] tile,
  input  logic [K*K*KW*C-1:0] kernel,
  output logic [M*M*OW-1:0]   result
);

  // The product is formed at full width before extending to OW, so it never truncates.
  function automatic logic signed [OW-1:0] mac_term(input logic [DW-1:0] pix,
                                                    input logic signed [KW-1:0] coef);
    logic signed [DW:0]    pix_s;
    logic signed [DW+KW:0] prod;
    pix_s = $signed({1'b0, pix});
    prod  = (DW+KW+1)'(pix_s) * (DW+KW+1)'(coef);
    return OW'(prod);
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < M; gi++) begin : g_row
      for (gj = 0; gj < M; gj++) begin : g_col
        logic signed [OW-1:0] acc;

        always_comb begin
          acc = '0;
          for (int ch = 0; ch < C; ch++) begin
            for (int kr = 0; kr < K; kr++) begin
              for (int kc = 0; kc < K; kc++) begin
                acc = acc + mac_term(tile[tile_idx(ch, gi + kr, gj + kc, T, DW) +: DW],
                                     kernel[kernel_idx(ch, kr, kc, K, KW) +: KW]);
              end
            end
          end
        end

        assign result[out_idx(gi, gj, M, OW) +: OW] = acc;
      end
    end
  endgenerate

endmodule

// File: rtl/top_v1.sv
// Streaming tiled 3x3 convolution: raster pixels with interleaved channels in,
// one 2x2 output block registered two edges after each tile's final sample.
module top_v1
  import top_v1_pkg::*;
#(
  parameter int KERNEL_SIZE       = 3,
  parameter int INPUT_IMAGE_WIDTH = 10,
  parameter int INPUT_TILE_SIZE   = 4,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int CHANNELS          = 3
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic [INPUT_DATA_WIDTH-1:0]                                 i_pixel_data,
  input  logic                                                        i_pixel_data_valid,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH*CHANNELS-1:0] Kernel,
  output logic [out_tile(INPUT_TILE_SIZE, KERNEL_SIZE)*out_tile(INPUT_TILE_SIZE, KERNEL_SIZE)*out_width(KERNEL_DATA_WIDTH, INPUT_DATA_WIDTH)-1:0] outData
);

  localparam int K     = KERNEL_SIZE;
  localparam int W     = INPUT_IMAGE_WIDTH;
  localparam int T     = INPUT_TILE_SIZE;
  localparam int DW    = INPUT_DATA_WIDTH;
  localparam int KW    = KERNEL_DATA_WIDTH;
  localparam int C     = CHANNELS;
  localparam int M     = out_tile(T, K);
  localparam int OW    = out_width(KW, DW);
  localparam int NT    = tiles_per_dim(W, K, M);
  localparam int CW    = width_min1(C);
  localparam int PW    = width_min1(W);
  localparam int SW    = width_min1(T);
  localparam int KBITS = K * K * KW * C;
  localparam int TBITS = T * T * DW * C;
  localparam int OBITS = M * M * OW;
  localparam int LAST_END = M * (NT - 1) + T - 1;

  logic [CW-1:0] ch_reg, ch_next;
  logic [PW-1:0] col_reg, col_next;
  logic [PW-1:0] row_reg, row_next;
  logic          tile_done;

  logic [DW-1:0] line_mem [C][T][W];

  logic             s1_valid_reg;
  logic [SW-1:0]    s1_slot_reg;
  logic [PW-1:0]    s1_col_reg;
  logic [KBITS-1:0] s1_kernel_reg;
  logic             s2_valid_reg;
  logic [KBITS-1:0] s2_kernel_reg;
  logic [TBITS-1:0] tile_reg;
  logic [TBITS-1:0] tile_rd;
  logic [OBITS-1:0] conv_out;

  always_comb begin
    ch_next  = ch_reg;
    col_next = col_reg;
    row_next = row_reg;
    if (ch_reg == CW'(C - 1)) begin
      ch_next = '0;
      if (col_reg == PW'(W - 1)) begin
        col_next = '0;
        row_next = (row_reg == PW'(W - 1)) ? '0 : row_reg + PW'(1);
      end else begin
        col_next = col_reg + PW'(1);
      end
    end else begin
      ch_next = ch_reg + CW'(1);
    end
  end

  // The last channel at an odd row/column of at least T-1 closes the tile anchored T-1 back;
  // positions past the last full tile (odd-width remainder) are ignored.
  assign tile_done = i_pixel_data_valid
                   && (ch_reg == CW'(C - 1))
                   && row_reg[0] && col_reg[0]
                   && (row_reg >= PW'(T - 1)) && (col_reg >= PW'(T - 1))
                   && (row_reg <= PW'(LAST_END)) && (col_reg <= PW'(LAST_END));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_reg  <= '0;
      col_reg <= '0;
      row_reg <= '0;
    end else if (i_pixel_data_valid) begin
      ch_reg  <= ch_next;
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // Rows live in slot (row mod T), so the T most recent rows of every channel stay resident.
  always_ff @(posedge clk) begin
    if (i_pixel_data_valid) begin
      line_mem[ch_reg][row_reg[SW-1:0]][col_reg] <= i_pixel_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= tile_done;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // The kernel is captured together with the completing sample, so later edits hit later tiles only.
  always_ff @(posedge clk) begin
    if (tile_done) begin
      s1_slot_reg   <= row_reg[SW-1:0] - SW'(T - 1);
      s1_col_reg    <= col_reg - PW'(T - 1);
      s1_kernel_reg <= Kernel;
    end
  end

  genvar gi, gr, gc;
  generate
    for (gi = 0; gi < C; gi++) begin : g_ch
      for (gr = 0; gr < T; gr++) begin : g_r
        for (gc = 0; gc < T; gc++) begin : g_c
          assign tile_rd[tile_idx(gi, gr, gc, T, DW) +: DW] =
            line_mem[gi][SW'(s1_slot_reg + SW'(gr))][PW'(s1_col_reg + PW'(gc))];
        end
      end
    end
  endgenerate

  // Tile snapshot is taken one edge after completion, before the next sample can overwrite it.
  always_ff @(posedge clk) begin
    if (s1_valid_reg) begin
      tile_reg      <= tile_rd;
      s2_kernel_reg <= s1_kernel_reg;
    end
  end

  tile_conv_2x2 #(
    .K  (K),
    .T  (T),
    .DW (DW),
    .KW (KW),
    .C  (C),
    .M  (M),
    .OW (OW)
  ) u_conv (
    .tile   (tile_reg),
    .kernel (s2_kernel_reg),
    .result (conv_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outData <= '0;
    end else if (s2_valid_reg) begin
      outData <= conv_out;
    end
  end

endmodule

// File: tb/tb_top_v1.sv
// Scoreboard bench for top_v1: stimulus pushes timed expected 2x2 blocks,
// a monitor compares outData every cycle against the block due at that edge.
module tb_top_v1;

  localparam int W  = 10;
  localparam int C  = 3;
  localparam int K  = 3;
  localparam int DW = 8;
  localparam int KW = 8;
  localparam int OW = 29;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [DW-1:0]        i_pixel_data = '0;
  logic                 i_pixel_data_valid = 1'b0;
  logic [K*K*KW*C-1:0]  Kernel = '0;
  logic [4*OW-1:0]      outData;

  top_v1 dut (
    .clk                (clk),
    .reset              (reset),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .Kernel             (Kernel),
    .outData            (outData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int due;
    int e0;
    int e1;
    int e2;
    int e3;
  } exp_t;

  exp_t q[$];
  int   hold[4];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pix[C][W][W];
  int   kern[C][K][K];
  int   b_ch = 0, b_col = 0, b_row = 0;
  int   kseq = 0;
  int   hand_mode = 0;
  int   hand[4];
  bit   first_pending = 1'b0;

  function automatic int get_out(input int idx);
    logic signed [OW-1:0] v;
    v = outData[idx*OW +: OW];
    return int'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      hold[0] = e.e0; hold[1] = e.e1; hold[2] = e.e2; hold[3] = e.e3;
      $display("tile update cyc=%0d out=%0d %0d %0d %0d",
               cyc, get_out(0), get_out(1), get_out(2), get_out(3));
    end
    check("out00", get_out(0), hold[0]);
    check("out01", get_out(1), hold[1]);
    check("out10", get_out(2), hold[2]);
    check("out11", get_out(3), hold[3]);
  end

  task automatic drive_kernel();
    for (int ch = 0; ch < C; ch++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          Kernel[((ch*K+kr)*K+kc)*KW +: KW] = KW'(kern[ch][kr][kc]);
  endtask

  task automatic fill_kernel(input int v);
    for (int ch = 0; ch < C; ch++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          kern[ch][kr][kc] = v;
    drive_kernel();
  endtask

  task automatic random_kernel();
    for (int ch = 0; ch < C; ch++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          kern[ch][kr][kc] = int'($urandom_range(0, 255)) - 128;
    drive_kernel();
  endtask

  task automatic push_tile(input int ar, input int ac);
    exp_t e;
    int   v[4];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        v[r*2+c] = 0;
        for (int ch = 0; ch < C; ch++)
          for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++)
              v[r*2+c] += pix[ch][ar+r+kr][ac+c+kc] * kern[ch][kr][kc];
      end
    if (hand_mode == 2 || (hand_mode == 1 && first_pending)) begin
      for (int i = 0; i < 4; i++) v[i] = hand[i];
    end
    first_pending = 1'b0;
    e.due = cyc + 3;
    e.e0 = v[0]; e.e1 = v[1]; e.e2 = v[2]; e.e3 = v[3];
    q.push_back(e);
  endtask

  task automatic send(input int p, input int kmode);
    int idx;
    @(negedge clk);
    idx = (b_row*W + b_col)*C + b_ch;
    if ((kmode >= 1 && idx == 0) || (kmode == 2 && idx == 150)) random_kernel();
    i_pixel_data = DW'(p);
    i_pixel_data_valid = 1'b1;
    pix[b_ch][b_row][b_col] = p;
    if (b_ch == C-1 && b_row >= 3 && b_col >= 3 && (b_row % 2) == 1 && (b_col % 2) == 1)
      push_tile(b_row - 3, b_col - 3);
    if (b_ch == C-1) begin
      b_ch = 0;
      if (b_col == W-1) begin
        b_col = 0;
        b_row = (b_row == W-1) ? 0 : b_row + 1;
      end else begin
        b_col++;
      end
    end else begin
      b_ch++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_pixel_data_valid = 1'b0;
      i_pixel_data = DW'($urandom_range(0, 255));
    end
  endtask

  // pmode 0: ramp k mod 256; pmode 1: constant pconst.
  task automatic run(input int n, input int pmode, input int pconst, input bit gaps, input int kmode);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (pmode == 0) begin
        send(kseq % 256, kmode);
        kseq++;
      end else begin
        send(pconst, kmode);
      end
    end
  endtask

  task automatic drain();
    idle(6);
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_pixel_data_valid = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) hold[i] = 0;
    #1;
    for (int i = 0; i < 4; i++) check("reset_clear", get_out(i), 0);
    b_ch = 0; b_col = 0; b_row = 0;
    kseq = 0;
    first_pending = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) hold[i] = 0;
    fill_kernel(1);
    #1;
    do_reset();

    // Ramp stream, all +1 kernel: two frames, first tile hand-computed.
    hand_mode = 1;
    hand[0] = 918; hand[1] = 999; hand[2] = 1728; hand[3] = 1809;
    run(600, 0, 0, 1'b0, 0);
    drain();

    // Only (ch0,1,1)=+1 with constant pixels 5.
    fill_kernel(0);
    kern[0][1][1] = 1;
    drive_kernel();
    hand_mode = 2;
    for (int i = 0; i < 4; i++) hand[i] = 5;
    run(300, 1, 5, 1'b0, 0);
    drain();

    // All -1 kernel with saturated pixels: large negative sums.
    fill_kernel(-1);
    for (int i = 0; i < 4; i++) hand[i] = -6885;
    run(300, 1, 255, 1'b0, 0);
    drain();

    // Ramp stream with random stalls.
    fill_kernel(1);
    do_reset();
    hand_mode = 1;
    hand[0] = 918; hand[1] = 999; hand[2] = 1728; hand[3] = 1809;
    run(600, 0, 0, 1'b1, 0);
    drain();

    // Reset right after frame 2's first tile completes, then restart.
    do_reset();
    run(402, 0, 0, 1'b0, 0);
    do_reset();
    run(300, 0, 0, 1'b0, 0);
    drain();

    // Six back-to-back frames, new kernel each frame plus a mid-frame change.
    hand_mode = 0;
    for (int f = 0; f < 6; f++) begin
      run(300, 0, 0, (f == 4), (f == 2) ? 2 : 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
